sync_fifo: RTL and testbench
============================

SYNC_FIFO -- requirements
Module: sync_fifo

Interface
REQ-001 The parameter DATA_WIDTH SHALL default to 8 and set the data word width in bits.
REQ-002 The parameter DEPTH SHALL default to 16 and set the storage capacity in words; legal values are powers of two, 2 or greater.
REQ-003 The parameter ADDR_WIDTH SHALL default to 4 and equal log2(DEPTH).
REQ-004 Port clk: input, 1 bit; the single clock; all state changes occur on its rising edge.
REQ-005 Port rst: input, 1 bit; one clock; reset is synchronous and active-high.
REQ-006 Port wr_en: input, 1 bit; write request, sampled on the rising edge of clk.
REQ-007 Port data_in: input, DATA_WIDTH bits; write data, sampled with wr_en.
REQ-008 Port rd_en: input, 1 bit; read request, sampled on the rising edge of clk.
REQ-009 Port data_out: output, DATA_WIDTH bits; registered read data.
REQ-010 Port empty: output, 1 bit; high when the FIFO holds 0 words.
REQ-011 Port full: output, 1 bit; high when the FIFO holds DEPTH words.

Function
REQ-012 Internal state SHALL be:
- storage array of DEPTH x DATA_WIDTH
- write pointer and read pointer, each ADDR_WIDTH bits, wrapping modulo DEPTH
- occupancy count of ADDR_WIDTH+1 bits, range 0..DEPTH
REQ-013 An accepted write SHALL occur when wr_en=1 and full=0 at a rising edge: data_in is stored at the write pointer and the write pointer increments.
REQ-014 An accepted read SHALL occur when rd_en=1 and empty=0 at a rising edge: the word at the read pointer is loaded into data_out on that edge and the read pointer increments. Read latency is one cycle.
REQ-015 data_out SHALL hold its previous value in every cycle without an accepted read.
REQ-016 wr_en=1 while full=1 SHALL be ignored: no storage, pointer or count change, and no error indication.
REQ-017 rd_en=1 while empty=1 SHALL be ignored: data_out, pointers and count are unchanged.
REQ-018 Simultaneous wr_en=1 and rd_en=1 SHALL behave as follows:
- when neither empty nor full: both accepted, count unchanged
- when empty: only the write is accepted, count becomes 1
- when full: both accepted, count stays DEPTH and full stays 1
REQ-019 Count update: +1 on write only; -1 on read only; unchanged otherwise.
REQ-020 empty SHALL equal (count==0) and full SHALL equal (count==DEPTH), decoded from registered state with no combinational path from wr_en or rd_en. Flags update on the same edge as the accepted access.
REQ-021 Pointer wrap from DEPTH-1 to 0 SHALL be seamless; data order is strictly first-in first-out across the wrap.
REQ-022 X-free behaviour SHALL hold after reset; storage contents need not be reset, and a stale entry is never presented because reads are gated by empty.

Reset
REQ-023 When rst=1 at a rising edge, the block SHALL set both pointers to 0, count to 0, data_out to 0, empty to 1 and full to 0.
REQ-024 rst SHALL take priority over wr_en and rd_en in the same cycle; reset mid-operation discards all stored words.
REQ-025 The first access SHALL be accepted on the first rising edge at which rst=0.

Verification
REQ-026 Reset check: hold rst=1 for 2 cycles -> empty=1, full=0, data_out=0.
REQ-027 Fill and overflow: write 1..20 on consecutive cycles, no reads ->
- empty falls after the first write
- full rises after the 16th write
- writes 17..20 are dropped
REQ-028 Drain and underflow: after REQ-027, hold rd_en=1 for 20 cycles ->
- data_out shows 1..16 on successive cycles, each one cycle after its read edge
- empty rises with the 16th read
- data_out then holds 16
REQ-029 Simultaneous access: with 5 words stored, hold wr_en=1 and rd_en=1 for 30 cycles -> count stays 5, both flags stay 0, output order is preserved across the pointer wrap.
REQ-030 Corner simultaneous access: assert wr_en and rd_en together when empty -> count becomes 1 and data_out is unchanged; repeat when full -> count stays 16, full stays 1, and the oldest word is output.
REQ-031 Mid-operation reset: store 7 words, assert rst=1 for 1 cycle together with wr_en=1 -> empty=1, data_out=0, and a subsequent read returns only newly written data.

Source files
------------

// File: rtl/sync_fifo.sv
// Single-clock FIFO with a registered read port.
// Storage is a plain register array; occupancy is tracked with an explicit
// count so empty/full are simple decodes of registered state.
module sync_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  empty,
  output logic                  full
);

  localparam logic [ADDR_WIDTH:0]   FULL_CNT = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH:0]   CNT_ONE  = (ADDR_WIDTH+1)'(1);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_WIDTH:0]   count_q,  count_d;
  logic [DATA_WIDTH-1:0] dout_q,   dout_d;

  logic wr_acc, rd_acc;

  assign empty    = (count_q == '0);
  assign full     = (count_q == FULL_CNT);
  assign data_out = dout_q;

  // Accept decode: a write while full is allowed only when paired with a read,
  // since the read frees the slot the write lands in (wr_ptr == rd_ptr).
  // A read while empty is never accepted, so stale storage is never shown.
  always_comb begin
    rd_acc = rd_en && !empty;
    wr_acc = wr_en && (!full || rd_acc);
  end

  // Next-state for pointers, count and output register.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    dout_d   = dout_q;
    if (wr_acc) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (rd_acc) begin
      rd_ptr_d = rd_ptr_q + PTR_ONE;
      dout_d   = mem_q[rd_ptr_q];
    end
    case ({wr_acc, rd_acc})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // Control and output registers; synchronous reset wins over any access.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      dout_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      dout_q   <= dout_d;
    end
  end

  // Storage write; contents are not reset, reads are gated by count instead.
  always_ff @(posedge clk) begin
    if (!rst && wr_acc) mem_q[wr_ptr_q] <= data_in;
  end

endmodule

// File: tb/tb_sync_fifo.sv
// Directed bench for sync_fifo (DEPTH=16, DATA_WIDTH=8).
module tb_sync_fifo;

  logic       clk = 1'b0;
  logic       rst;
  logic       wr_en;
  logic [7:0] data_in;
  logic       rd_en;
  logic [7:0] data_out;
  logic       empty;
  logic       full;

  int n_chk = 0;
  int n_err = 0;

  sync_fifo #(.DATA_WIDTH(8), .DEPTH(16), .ADDR_WIDTH(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (wr_en),
    .data_in  (data_in),
    .rd_en    (rd_en),
    .data_out (data_out),
    .empty    (empty),
    .full     (full)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drive one cycle of inputs, then sample 1 time unit after the edge.
  task automatic step(input logic w, input logic [7:0] d, input logic r);
    wr_en = w; data_in = d; rd_en = r;
    @(posedge clk); #1;
    wr_en = 1'b0; rd_en = 1'b0; data_in = '0;
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; data_in = '0;

    // Reset held for two cycles
    step(1'b0, 8'h00, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full",  32'(full),  32'd0);
    chk("rst_dout",  32'(data_out), 32'd0);
    rst = 1'b0;

    // Fill with 1..20; 17..20 must be dropped
    for (int i = 1; i <= 20; i++) begin
      step(1'b1, 8'(i), 1'b0);
      chk("fill_empty", 32'(empty), 32'd0);
      chk("fill_full",  32'(full),  (i >= 16) ? 32'd1 : 32'd0);
    end
    chk("fill_dout", 32'(data_out), 32'd0);

    // Drain with rd_en held 20 cycles
    for (int k = 1; k <= 20; k++) begin
      step(1'b0, 8'h00, 1'b1);
      chk("drain_dout",  32'(data_out), (k >= 16) ? 32'd16 : 32'(k));
      chk("drain_empty", 32'(empty),   (k >= 16) ? 32'd1 : 32'd0);
      chk("drain_full",  32'(full),    32'd0);
    end

    // 5 words stored, then 30 cycles of simultaneous access across the wrap
    for (int i = 0; i < 5; i++) step(1'b1, 8'(100 + i), 1'b0);
    for (int j = 0; j < 30; j++) begin
      step(1'b1, 8'(105 + j), 1'b1);
      chk("simul_dout",  32'(data_out), 32'(100 + j));
      chk("simul_empty", 32'(empty), 32'd0);
      chk("simul_full",  32'(full),  32'd0);
    end
    // Exactly five words remain: 130..134
    for (int k = 0; k < 5; k++) begin
      step(1'b0, 8'h00, 1'b1);
      chk("simul_tail", 32'(data_out), 32'(130 + k));
      chk("simul_tail_empty", 32'(empty), (k == 4) ? 32'd1 : 32'd0);
    end

    // Simultaneous access while empty: write only, output unchanged
    step(1'b1, 8'hAA, 1'b1);
    chk("ce_dout",  32'(data_out), 32'd134);
    chk("ce_empty", 32'(empty), 32'd0);
    chk("ce_full",  32'(full),  32'd0);
    step(1'b0, 8'h00, 1'b1);
    chk("ce_read",  32'(data_out), 32'hAA);
    chk("ce_count1", 32'(empty), 32'd1);

    // Simultaneous access while full: both accepted, stays full
    for (int i = 0; i < 16; i++) step(1'b1, 8'(200 + i), 1'b0);
    chk("cf_pre_full", 32'(full), 32'd1);
    step(1'b1, 8'h55, 1'b1);
    chk("cf_dout", 32'(data_out), 32'd200);
    chk("cf_full", 32'(full), 32'd1);
    for (int k = 0; k < 16; k++) begin
      step(1'b0, 8'h00, 1'b1);
      chk("cf_drain", 32'(data_out), (k == 15) ? 32'h55 : 32'(201 + k));
      chk("cf_drain_empty", 32'(empty), (k == 15) ? 32'd1 : 32'd0);
    end

    // Mid-operation reset together with a write
    for (int i = 1; i <= 7; i++) step(1'b1, 8'(i), 1'b0);
    step(1'b0, 8'h00, 1'b1);
    chk("mr_pre_read", 32'(data_out), 32'd1);
    rst = 1'b1;
    step(1'b1, 8'hEE, 1'b0);
    rst = 1'b0;
    chk("mr_empty", 32'(empty), 32'd1);
    chk("mr_full",  32'(full),  32'd0);
    chk("mr_dout",  32'(data_out), 32'd0);
    step(1'b0, 8'h00, 1'b1);
    chk("mr_underflow_dout", 32'(data_out), 32'd0);
    step(1'b1, 8'h3C, 1'b0);
    chk("mr_first_wr", 32'(empty), 32'd0);
    step(1'b0, 8'h00, 1'b1);
    chk("mr_new_data", 32'(data_out), 32'h3C);
    chk("mr_end_empty", 32'(empty), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
